adsb_frame_sched: RTL and testbench

Frame scheduler between the ADS-B bit demodulator and the SPI byte engine in the adsb2spi path. Packs demodulated Manchester bits into bytes, buffers up to two complete frames, and sequences each buffered frame onto the SPI link as one chip-select-framed burst: header byte, then data bytes. Frames that arrive with no free buffer, or that contain a Manchester error, are dropped and flagged.

---
 rtl/adsb_frame_sched.sv | 241 ++++++++++++++++++++++++
 tb/tb_adsb_frame_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsb_frame_sched.sv
// adsb_frame_sched
// Sits between the ADS-B bit demodulator and the SPI byte engine. Decoded
// bits are packed MSB-first into bytes and stored in one of two frame slots,
// which are used as a 2-entry FIFO. Each full slot is sent as one burst with
// spi_ss held low: a header byte {4'hA, seq} followed by the frame bytes.
// A frame is dropped, and frame_drop pulses, when it contains a Manchester
// error or when no slot is free at its sync_det.
//
// Ports
//   clk8M          in   system clock, rising edge
//   rst            in   asynchronous reset, active low
//   sync_det       in   preamble matched; frame bits follow
//   bit_valid      in   bit_data holds one decoded bit
//   bit_data       in   decoded bit, MSB of the frame first
//   bit_err        in   invalid Manchester pair in the current frame
//   spi_byte       out  byte offered to the SPI engine
//   spi_byte_valid out  spi_byte is valid
//   spi_byte_ready in   engine idle and shifter empty
//   spi_ss         out  active-low chip select
//   frame_drop     out  one-cycle pulse per discarded frame
//   busy           out  a slot is full or a burst is in progress
//
// Capture FSM
//   state  | meaning
//   C_IDLE | waiting for sync_det; stray bits ignored
//   C_CAPT | packing bits into slot[wr_ptr]
//
// TX FSM
//   state   | meaning
//   T_IDLE  | spi_ss high, waiting for full[rd_ptr]
//   T_SETUP | spi_ss low, SS_SETUP cycles before the first byte
//   T_HDR   | header offered
//   T_DATA  | frame bytes offered
//   T_DRAIN | last byte accepted, waiting for the shifter to empty
//   T_GAP   | spi_ss high, SS_HOLD cycles before the next burst
module adsb_frame_sched #(
  parameter int FRAME_BITS = 112,
  parameter int SS_SETUP   = 4,
  parameter int SS_HOLD    = 4
) (
  input  logic       clk8M,
  input  logic       rst,
  input  logic       sync_det,
  input  logic       bit_valid,
  input  logic       bit_data,
  input  logic       bit_err,
  output logic [7:0] spi_byte,
  output logic       spi_byte_valid,
  input  logic       spi_byte_ready,
  output logic       spi_ss,
  output logic       frame_drop,
  output logic       busy
);

  localparam int N_BYTES = FRAME_BITS / 8;
  localparam int BC_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int IDX_W   = $clog2(N_BYTES + 1);
  localparam int TMR_W   = 8;

  typedef enum logic {C_IDLE, C_CAPT} cap_state_t;
  typedef enum logic [2:0] {T_IDLE, T_SETUP, T_HDR, T_DATA, T_DRAIN, T_GAP} tx_state_t;

  cap_state_t       r_cap_state;
  tx_state_t        r_tx_state;

  logic [7:0]       r_mem [2][N_BYTES];
  logic [1:0]       r_full;
  logic             r_wr_ptr;
  logic             r_rd_ptr;

  logic [6:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [BC_W-1:0]  r_byte_cnt;
  logic             r_frame_drop;

  logic [IDX_W-1:0] r_tx_idx;
  logic [TMR_W-1:0] r_tmr;
  logic [3:0]       r_seq;
  logic [7:0]       r_spi_byte;
  logic             r_spi_valid;
  logic             r_spi_ss;

  logic             w_byte_wr;
  logic             w_last_byte;
  logic             w_cap_done;
  logic             w_tx_done;
  logic             w_accept;
  logic [1:0]       w_full_set;
  logic [1:0]       w_full_clr;

  // A bit only counts when no error or restart arrives in the same cycle.
  assign w_byte_wr   = (r_cap_state == C_CAPT) && bit_valid && !bit_err && !sync_det
                       && (r_bit_cnt == 3'd7);
  assign w_last_byte = (r_byte_cnt == BC_W'(N_BYTES - 1));
  assign w_cap_done  = w_byte_wr && w_last_byte;
  assign w_tx_done   = (r_tx_state == T_DRAIN) && spi_byte_ready;
  assign w_accept    = r_spi_valid && spi_byte_ready;

  // Capture only ever targets a free slot and TX only releases a full one,
  // so a set and a clear in the same cycle always hit different slots.
  assign w_full_set  = w_cap_done ? {r_wr_ptr, ~r_wr_ptr} : 2'b00;
  assign w_full_clr  = w_tx_done  ? {r_rd_ptr, ~r_rd_ptr} : 2'b00;

  always_ff @(posedge clk8M or negedge rst) begin
    if (!rst) begin
      r_cap_state  <= C_IDLE;
      r_wr_ptr     <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_frame_drop <= 1'b0;
    end else begin
      r_frame_drop <= 1'b0;
      case (r_cap_state)
        C_IDLE: begin
          if (sync_det) begin
            if (!r_full[r_wr_ptr]) begin
              r_bit_cnt   <= '0;
              r_byte_cnt  <= '0;
              r_cap_state <= C_CAPT;
            end else begin
              r_frame_drop <= 1'b1;
            end
          end
        end
        C_CAPT: begin
          if (bit_err) begin
            r_frame_drop <= 1'b1;
            r_cap_state  <= C_IDLE;
          end else if (sync_det) begin
            // new preamble: silently restart in the same slot
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
          end else if (bit_valid) begin
            r_shift   <= {r_shift[5:0], bit_data};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_byte_cnt <= r_byte_cnt + BC_W'(1);
              if (w_last_byte) begin
                r_wr_ptr    <= ~r_wr_ptr;
                r_cap_state <= C_IDLE;
              end
            end
          end
        end
        default: r_cap_state <= C_IDLE;
      endcase
    end
  end

  // Frame storage carries no reset; a slot is only read once full is set.
  always_ff @(posedge clk8M) begin
    if (w_byte_wr) begin
      r_mem[r_wr_ptr][r_byte_cnt] <= {r_shift, bit_data};
    end
  end

  always_ff @(posedge clk8M or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  always_ff @(posedge clk8M or negedge rst) begin
    if (!rst) begin
      r_tx_state  <= T_IDLE;
      r_rd_ptr    <= 1'b0;
      r_tx_idx    <= '0;
      r_tmr       <= '0;
      r_seq       <= 4'd0;
      r_spi_byte  <= 8'h00;
      r_spi_valid <= 1'b0;
      r_spi_ss    <= 1'b1;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (r_full[r_rd_ptr]) begin
            r_spi_ss   <= 1'b0;
            r_tmr      <= TMR_W'(SS_SETUP - 1);
            r_tx_state <= T_SETUP;
          end
        end
        T_SETUP: begin
          if (r_tmr == '0) begin
            r_spi_byte  <= {4'hA, r_seq};
            r_spi_valid <= 1'b1;
            r_tx_state  <= T_HDR;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        T_HDR: begin
          if (w_accept) begin
            r_spi_byte <= r_mem[r_rd_ptr][0];
            r_tx_idx   <= IDX_W'(1);
            r_tx_state <= T_DATA;
          end
        end
        T_DATA: begin
          // r_tx_idx is the index of the byte to present next, so reaching
          // N_BYTES on an accept means the last byte just went out.
          if (w_accept) begin
            if (r_tx_idx == IDX_W'(N_BYTES)) begin
              r_spi_valid <= 1'b0;
              r_tx_state  <= T_DRAIN;
            end else begin
              r_spi_byte <= r_mem[r_rd_ptr][r_tx_idx[BC_W-1:0]];
              r_tx_idx   <= r_tx_idx + IDX_W'(1);
            end
          end
        end
        T_DRAIN: begin
          if (spi_byte_ready) begin
            r_spi_ss   <= 1'b1;
            r_rd_ptr   <= ~r_rd_ptr;
            r_seq      <= r_seq + 4'd1;
            r_tmr      <= TMR_W'(SS_HOLD - 1);
            r_tx_state <= T_GAP;
          end
        end
        T_GAP: begin
          if (r_tmr == '0) begin
            r_tx_state <= T_IDLE;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  assign spi_byte       = r_spi_byte;
  assign spi_byte_valid = r_spi_valid;
  assign spi_ss         = r_spi_ss;
  assign frame_drop     = r_frame_drop;
  assign busy           = (|r_full) || (r_tx_state != T_IDLE);

endmodule

// File: tb/tb_adsb_frame_sched.sv
// Testbench for adsb_frame_sched: scenario table, hand sequences for stall,
// overflow and reset, and a randomized run against a frame-level model.
module tb_adsb_frame_sched;

  localparam int FB       = 112;
  localparam int NB       = FB / 8;
  localparam int SS_SETUP = 4;
  localparam int SS_HOLD  = 4;

  localparam logic [FB-1:0] FRAME_A = 112'h8D4840D6202CC371C32CE0576098;
  localparam logic [FB-1:0] FRAME_B = 112'h5D3C6614A2E1F0877B19C4D0035A;
  localparam logic [FB-1:0] FRAME_C = 112'h8DABCDEF990D1234567890ABCDEF;

  logic       clk8M = 1'b0;
  logic       rst = 1'b0;
  logic       sync_det = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b0;
  logic       bit_err = 1'b0;
  logic       spi_byte_ready = 1'b1;
  logic [7:0] spi_byte;
  logic       spi_byte_valid;
  logic       spi_ss;
  logic       frame_drop;
  logic       busy;

  adsb_frame_sched #(.FRAME_BITS(FB), .SS_SETUP(SS_SETUP), .SS_HOLD(SS_HOLD)) dut (
    .clk8M(clk8M), .rst(rst), .sync_det(sync_det), .bit_valid(bit_valid),
    .bit_data(bit_data), .bit_err(bit_err), .spi_byte(spi_byte),
    .spi_byte_valid(spi_byte_valid), .spi_byte_ready(spi_byte_ready),
    .spi_ss(spi_ss), .frame_drop(frame_drop), .busy(busy)
  );

  always #5 clk8M = ~clk8M;

  int cyc = 0;
  always @(posedge clk8M) cyc <= cyc + 1;

  int compares = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compares++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- engine model and bus monitor ----------------
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int  n_bursts = 0, n_drops = 0;
  int  ss_fall_cyc = -1, ss_rise_cyc = -1, last_gap = -1, hdr_cyc = -1;
  int  last_bit_cyc = 0;
  bit  stall = 1'b0;
  int  eng_cnt = 0;
  bit  want_hdr = 1'b0;
  logic prev_ss = 1'b1, prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  initial begin
    logic acc;
    forever begin
      @(negedge clk8M);
      acc = spi_byte_valid && spi_byte_ready;
      if (rst && prev_rst && prev_valid && !prev_ready) begin
        check("hold_valid", {31'd0, spi_byte_valid}, 32'd1);
        check("hold_byte", {24'd0, spi_byte}, {24'd0, prev_byte});
      end
      if (acc) begin
        got_q.push_back(spi_byte);
        if (spi_ss) check("accept_with_ss_high", {31'd0, spi_ss}, 32'd0);
      end
      if (prev_ss && !spi_ss) begin
        n_bursts++;
        if (ss_rise_cyc >= 0) last_gap = cyc - ss_rise_cyc;
        ss_fall_cyc = cyc;
        want_hdr = 1'b1;
      end
      if (!prev_ss && spi_ss) ss_rise_cyc = cyc;
      if (want_hdr && spi_byte_valid) begin
        hdr_cyc = cyc;
        want_hdr = 1'b0;
      end
      if (frame_drop) n_drops++;
      prev_ss = spi_ss; prev_valid = spi_byte_valid; prev_ready = spi_byte_ready;
      prev_byte = spi_byte; prev_rst = rst;
      @(posedge clk8M); #1;
      // each accepted byte keeps the shifter busy for 8 cycles
      if (acc) begin
        spi_byte_ready = 1'b0;
        eng_cnt = 8;
      end else begin
        if (eng_cnt > 0) eng_cnt--;
        if (eng_cnt == 0) spi_byte_ready = !stall;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk8M); #1;
  endtask

  task automatic pulse_sync;
    sync_det = 1'b1; tick; sync_det = 1'b0;
  endtask

  task automatic send_bits(input logic [FB-1:0] d, input int n, input int err_at, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i == err_at) begin
        bit_err = 1'b1; tick; bit_err = 1'b0;
        return;
      end
      bit_data = d[FB-1-i];
      bit_valid = 1'b1;
      last_bit_cyc = cyc;
      tick;
      bit_valid = 1'b0;
      repeat (gap - 1) tick;
    end
  endtask

  task automatic send_frame(input logic [FB-1:0] d, input int err_at, input int abort_at, input int gap);
    pulse_sync;
    if (abort_at >= 0) begin
      send_bits(~d, abort_at, -1, gap);
      pulse_sync;
    end
    send_bits(d, FB, err_at, gap);
  endtask

  // ---------------- reference model ----------------
  logic [3:0] seq = 4'd0;
  int exp_drops = 0;

  task automatic expect_frame(input logic [FB-1:0] d);
    exp_q.push_back({4'hA, seq});
    for (int b = 0; b < NB; b++) exp_q.push_back(d[FB-1-8*b -: 8]);
    seq = seq + 4'd1;
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    repeat (3) tick;
    while (!(busy === 1'b0 && spi_ss === 1'b1) && k < max_cyc) begin
      tick;
      k++;
    end
    if (k >= max_cyc) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_counts;
    n_bursts = 0; n_drops = 0; exp_drops = 0;
  endtask

  typedef struct {
    logic [FB-1:0] data;
    int            err_at;
    int            abort_at;
    int            exp_bursts;
    int            exp_drops;
    logic [7:0]    exp_hdr;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{FRAME_A, 40, -1, 0, 1, 8'h00};
    tbl[1] = '{FRAME_A, -1, -1, 1, 0, 8'hA0};
    tbl[2] = '{FRAME_B, -1, 20, 1, 0, 8'hA1};
    tbl[3] = '{FRAME_C, -1, -1, 1, 0, 8'hA2};

    // reset values
    repeat (3) tick;
    check("rst_ss", {31'd0, spi_ss}, 32'd1);
    check("rst_valid", {31'd0, spi_byte_valid}, 32'd0);
    check("rst_byte", {24'd0, spi_byte}, 32'd0);
    check("rst_drop", {31'd0, frame_drop}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (2) tick;

    // scenario table
    for (int r = 0; r < 4; r++) begin
      clear_counts;
      send_frame(tbl[r].data, tbl[r].err_at, tbl[r].abort_at, 2);
      wait_idle(3000);
      check($sformatf("tbl%0d_bursts", r), n_bursts, tbl[r].exp_bursts);
      check($sformatf("tbl%0d_drops", r), n_drops, tbl[r].exp_drops);
      if (tbl[r].exp_bursts == 1) begin
        check($sformatf("tbl%0d_hdr", r), {24'd0, got_q[0]}, {24'd0, tbl[r].exp_hdr});
        check($sformatf("tbl%0d_ss_lat", r), ss_fall_cyc - last_bit_cyc, 2);
        check($sformatf("tbl%0d_hdr_lat", r), hdr_cyc - last_bit_cyc, 2 + SS_SETUP);
        expect_frame(tbl[r].data);
      end
      compare_stream($sformatf("tbl%0d", r));
    end

    // stalled engine: two frames buffered, the third dropped
    clear_counts;
    stall = 1'b1;
    tick;
    send_frame(FRAME_B, -1, -1, 1);
    send_frame(FRAME_C, -1, -1, 1);
    send_frame(FRAME_A, -1, -1, 1);
    repeat (5) tick;
    check("stall_drops", n_drops, 1);
    check("stall_bursts_before", n_bursts, 1);
    check("stall_no_bytes", got_q.size(), 0);
    check("stall_busy", {31'd0, busy}, 32'd1);
    stall = 1'b0;
    wait_idle(3000);
    check("stall_bursts_after", n_bursts, 2);
    check("stall_ss_gap", last_gap, SS_HOLD + 1);
    expect_frame(FRAME_B);
    expect_frame(FRAME_C);
    compare_stream("stall");

    // randomized frames against the model; enough clean frames to wrap seq
    clear_counts;
    for (int f = 0; f < 24; f++) begin
      logic [FB-1:0] rd;
      int kind, err_at, abort_at;
      rd = '0;
      for (int w = 0; w < 4; w++) rd = {rd[FB-33:0], 32'($urandom)};
      kind = $urandom_range(0, 7);
      err_at = -1;
      abort_at = -1;
      if (kind == 0) err_at = $urandom_range(0, FB - 1);
      if (kind == 1) abort_at = $urandom_range(1, FB - 1);
      send_frame(rd, err_at, abort_at, $urandom_range(2, 3));
      if (err_at >= 0) exp_drops++;
      else expect_frame(rd);
      repeat ($urandom_range(0, 20)) tick;
    end
    wait_idle(5000);
    check("rand_drops", n_drops, exp_drops);
    check("rand_bursts", n_bursts, exp_q.size() / (NB + 1));
    compare_stream("rand");

    // reset in the middle of the data phase
    clear_counts;
    begin
      int k = 0;
      fork
        send_frame(FRAME_C, -1, -1, 2);
      join_none
      while (got_q.size() < 4 && k < 3000) begin
        tick;
        k++;
      end
      if (k >= 3000) check("rst_mid_timeout", 32'd1, 32'd0);
    end
    @(negedge clk8M); #2;
    rst = 1'b0;
    #1;
    check("midrst_ss", {31'd0, spi_ss}, 32'd1);
    check("midrst_valid", {31'd0, spi_byte_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    tick; tick;
    rst = 1'b1;
    tick;
    got_q.delete();
    exp_q.delete();
    clear_counts;
    seq = 4'd0;
    send_frame(FRAME_A, -1, -1, 2);
    wait_idle(3000);
    check("postrst_bursts", n_bursts, 1);
    expect_frame(FRAME_A);
    compare_stream("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
